// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rail_seq.sv
// Supply-settle reset sequencer: waits for a stable synchronized rail-good flag, then releases
// staged active-low resets one at a time; any rail loss re-asserts all resets and is counted.
module gf180mcu_fd_sc_mcu7t5v0__rail_seq #(
  parameter int unsigned N_STAGES      = 4,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned STAGE_GAP     = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic                PWRGOOD,
  input  logic                CLR_CNT,
  output logic [N_STAGES-1:0] RST_N,
  output logic                READY,
  output logic [CNT_W-1:0]    BO_CNT,
  inout  wire                 VDD,
  inout  wire                 VSS
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned GW = $clog2(STAGE_GAP + 1);

  typedef enum logic [1:0] {StOff, StSettle, StRelease, StOn} state_e;

  state_e              r_state;
  logic                r_pg_meta;
  logic                r_pg_s;
  logic [SW-1:0]       r_settle;
  logic [GW-1:0]       r_gap;
  logic [N_STAGES-1:0] r_rst_n;
  logic                r_ready;
  logic [CNT_W-1:0]    r_bo_cnt;

  logic                w_brownout;
  logic [N_STAGES-1:0] w_rst_next;
  wire                 w_unused_rails = VDD ^ VSS;

  // A pg_s drop only counts once the sequence has left OFF.
  assign w_brownout = !r_pg_s && (r_state != StOff);
  // Released bits form a thermometer from bit 0 upward.
  assign w_rst_next = (r_rst_n << 1) | N_STAGES'(1);

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state   <= StOff;
      r_pg_meta <= 1'b0;
      r_pg_s    <= 1'b0;
      r_settle  <= '0;
      r_gap     <= '0;
      r_rst_n   <= '0;
      r_ready   <= 1'b0;
      r_bo_cnt  <= '0;
    end else begin
      r_pg_meta <= PWRGOOD;
      r_pg_s    <= r_pg_meta;

      if (CLR_CNT) begin
        r_bo_cnt <= '0;
      end else if (w_brownout && (r_bo_cnt != {CNT_W{1'b1}})) begin
        r_bo_cnt <= r_bo_cnt + CNT_W'(1);
      end

      if (w_brownout) begin
        r_state <= StOff;
        r_rst_n <= '0;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          StOff: begin
            if (r_pg_s) begin
              r_state  <= StSettle;
              r_settle <= SW'(1);
            end
          end
          StSettle: begin
            if (r_settle == SW'(SETTLE_CYCLES)) begin
              r_rst_n <= w_rst_next;
              r_gap   <= '0;
              if (w_rst_next[N_STAGES-1]) begin
                r_state <= StOn;
                r_ready <= 1'b1;
              end else begin
                r_state <= StRelease;
              end
            end else begin
              r_settle <= r_settle + SW'(1);
            end
          end
          StRelease: begin
            if (r_gap == GW'(STAGE_GAP - 1)) begin
              r_rst_n <= w_rst_next;
              r_gap   <= '0;
              if (w_rst_next[N_STAGES-1]) begin
                r_state <= StOn;
                r_ready <= 1'b1;
              end
            end else begin
              r_gap <= r_gap + GW'(1);
            end
          end
          StOn: ;
          default: r_state <= StOff;
        endcase
      end
    end
  end

  assign RST_N  = r_rst_n;
  assign READY  = r_ready;
  assign BO_CNT = r_bo_cnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rail_seq.sv
// Directed bench for the rail reset sequencer: default instance plus a 1-stage, 2-bit-counter one.
module tb_gf180mcu_fd_sc_mcu7t5v0__rail_seq;

  logic       clk = 1'b0;
  logic       rn, pg, clr, pg2, clr2;
  logic [3:0] rst_n;
  logic       ready;
  logic [7:0] bo_cnt;
  logic [0:0] rst_n2;
  logic       ready2;
  logic [1:0] bo_cnt2;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int n = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__rail_seq dut (
    .CLK(clk), .RN(rn), .PWRGOOD(pg), .CLR_CNT(clr),
    .RST_N(rst_n), .READY(ready), .BO_CNT(bo_cnt), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__rail_seq #(
    .N_STAGES(1), .SETTLE_CYCLES(4), .STAGE_GAP(2), .CNT_W(2)
  ) dut2 (
    .CLK(clk), .RN(rn), .PWRGOOD(pg2), .CLR_CNT(clr2),
    .RST_N(rst_n2), .READY(ready2), .BO_CNT(bo_cnt2), .VDD(vdd), .VSS(vss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks the default instance's full release profile relative to n=0 at pg_s-cause time.
  task automatic chk_full_seq(input string tag);
    run_to(66); chk({tag, "_66"}, {27'b0, ready, rst_n}, 32'h00);
    run_to(67); chk({tag, "_67"}, {27'b0, ready, rst_n}, 32'h01);
    run_to(74); chk({tag, "_74"}, {27'b0, ready, rst_n}, 32'h01);
    run_to(75); chk({tag, "_75"}, {27'b0, ready, rst_n}, 32'h03);
    run_to(83); chk({tag, "_83"}, {27'b0, ready, rst_n}, 32'h07);
    run_to(90); chk({tag, "_90"}, {27'b0, ready, rst_n}, 32'h07);
    run_to(91); chk({tag, "_91"}, {27'b0, ready, rst_n}, 32'h1f);
  endtask

  initial begin
    rn = 1'b0; pg = 1'b1; clr = 1'b0; pg2 = 1'b0; clr2 = 1'b0;
    tick(); tick(); tick();
    chk("reset_outs", {19'b0, bo_cnt, ready, rst_n}, 32'h0);
    chk("reset_outs2", {29'b0, bo_cnt2, rst_n2}, 32'h0);

    // Power-up with rails already good.
    rn = 1'b1; n = 0;
    chk_full_seq("pwrup");
    chk("pwrup_bo", {24'b0, bo_cnt}, 32'd0);

    // Brownout from ON: two sync edges, then the FSM edge drops everything at once.
    run_to(100); pg = 1'b0;
    run_to(102); chk("on_drop_102", {27'b0, ready, rst_n}, 32'h1f);
    run_to(103); chk("on_drop_103", {19'b0, bo_cnt, ready, rst_n}, {19'b0, 8'd1, 5'h00});

    // Settle aborted at count 40 by a 5-cycle drop.
    run_to(110); pg = 1'b1; n = 0;
    run_to(42); pg = 1'b0;
    run_to(44); chk("settle_drop_44", {19'b0, bo_cnt, ready, rst_n}, {19'b0, 8'd1, 5'h00});
    run_to(45); chk("settle_drop_45", {24'b0, bo_cnt}, 32'd2);
    run_to(47); pg = 1'b1; n = 0;
    run_to(66); chk("resettle_66", {27'b0, ready, rst_n}, 32'h00);
    run_to(67); chk("resettle_67", {27'b0, ready, rst_n}, 32'h01);

    // Drop between stage-1 and stage-2 releases.
    run_to(75); chk("rel_drop_75", {27'b0, ready, rst_n}, 32'h03);
    run_to(77); pg = 1'b0;
    run_to(79); chk("rel_drop_79", {27'b0, ready, rst_n}, 32'h03);
    run_to(80); chk("rel_drop_80", {19'b0, bo_cnt, ready, rst_n}, {19'b0, 8'd3, 5'h00});
    run_to(85); pg = 1'b1; n = 0;
    run_to(66); chk("rel_restart_66", {27'b0, ready, rst_n}, 32'h00);
    run_to(67); chk("rel_restart_67", {27'b0, ready, rst_n}, 32'h01);

    // Clear alone.
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_only", {24'b0, bo_cnt}, 32'd0);

    // RN asserted mid-release.
    run_to(70); chk("rn_mid_pre", {27'b0, ready, rst_n}, 32'h01);
    rn = 1'b0;
    run_to(71); chk("rn_mid", {19'b0, bo_cnt, ready, rst_n}, 32'h0);
    run_to(73); rn = 1'b1; n = 0;
    chk_full_seq("rerun");

    // Single-stage, 2-bit counter instance.
    n = 0; pg2 = 1'b1;
    run_to(6); chk("s1_6", {30'b0, ready2, rst_n2}, 32'h0);
    run_to(7); chk("s1_7", {30'b0, ready2, rst_n2}, 32'h3);
    for (int i = 0; i < 5; i++) begin
      pg2 = 1'b0;
      tick(); tick(); tick();
      chk("s1_bo_cnt", {30'b0, bo_cnt2}, (i < 3) ? i + 1 : 3);
      chk("s1_bo_off", {30'b0, ready2, rst_n2}, 32'h0);
      pg2 = 1'b1;
      repeat (7) tick();
      chk("s1_bo_on", {30'b0, ready2, rst_n2}, 32'h3);
    end
    // Sixth brownout coincident with clear: clear wins.
    pg2 = 1'b0;
    tick(); tick(); clr2 = 1'b1;
    tick(); clr2 = 1'b0;
    chk("s1_clr_wins", {29'b0, bo_cnt2, ready2}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
